// File: rtl/cmpl_div.sv
// cmpl_div: sequential complex divider Q = A*conj(B)/|B|^2 with a shared bit-serial restoring divider
// Ports: clock, reset (sync, active-high); ivalid/ready accept handshake;
//   dataa_r/dataa_i = dividend A, datab_r/datab_i = divisor B (signed WIDTH);
//   ovalid = one-cycle result strobe; result_r/result_i = signed quotient with FRAC_BITS
//   fractional bits (WIDTH_O wide); div0 = B was 0+0i (qualified by ovalid).
// Option: define CMPL_DIV_ROUND_EN to compute one extra quotient bit and round half away from zero.
module cmpl_div #(
  parameter int WIDTH     = 16,
  parameter int FRAC_BITS = 8,
  parameter int WIDTH_O   = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ivalid,
  output logic               ready,
  input  logic [WIDTH-1:0]   dataa_r,
  input  logic [WIDTH-1:0]   dataa_i,
  input  logic [WIDTH-1:0]   datab_r,
  input  logic [WIDTH-1:0]   datab_i,
  output logic               ovalid,
  output logic [WIDTH_O-1:0] result_r,
  output logic [WIDTH_O-1:0] result_i,
  output logic               div0
);
  localparam int P = 2 * WIDTH + 1;
  localparam int D = P + FRAC_BITS;
`ifdef CMPL_DIV_ROUND_EN
  localparam int N = D + 1;
`else
  localparam int N = D;
`endif
  localparam int CW = $clog2(N);
  localparam int M = N > WIDTH_O ? N : WIDTH_O;
  localparam logic [WIDTH_O-1:0] MAXW = {1'b0, {(WIDTH_O - 1){1'b1}}};
  localparam logic [M-1:0] MAXM = M'(MAXW);
  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;
  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [WIDTH-1:0] ar_q, ai_q, br_q, bi_q;
  logic [P-1:0]    den_q, rem_r_q, rem_i_q;
  logic [N-1:0]    quo_r_q, quo_i_q;
  logic            neg_r_q, neg_i_q, zero_q;
  logic signed [P-1:0] num_r, num_i, den;
  logic [P-1:0]    mag_r, mag_i;
  assign num_r = P'($signed(ar_q)) * P'($signed(br_q)) + P'($signed(ai_q)) * P'($signed(bi_q));
  assign num_i = P'($signed(ai_q)) * P'($signed(br_q)) - P'($signed(ar_q)) * P'($signed(bi_q));
  assign den   = P'($signed(br_q)) * P'($signed(br_q)) + P'($signed(bi_q)) * P'($signed(bi_q));
  assign mag_r = num_r[P-1] ? -num_r : num_r;
  assign mag_i = num_i[P-1] ? -num_i : num_i;
  // One restoring step: the dividend register shifts its MSB into the
  // remainder and receives the new quotient bit at its LSB, so after all
  // iterations it holds the quotient.
  function automatic logic [P+N-1:0] step(input logic [P-1:0] rem, input logic [N-1:0] q,
                                          input logic [P-1:0] d);
    logic [P:0] sh, df;
    sh = {rem, q[N-1]};
    df = sh - {1'b0, d};
    step = df[P] ? {sh[P-1:0], q[N-2:0], 1'b0} : {df[P-1:0], q[N-2:0], 1'b1};
  endfunction
  // Round (optionally), saturate the magnitude, then reapply the sign;
  // saturation is symmetric so saturating the magnitude is equivalent.
  function automatic logic [WIDTH_O-1:0] fin(input logic [N-1:0] q, input logic neg);
    logic [M-1:0] m;
    logic [WIDTH_O-1:0] s;
`ifdef CMPL_DIV_ROUND_EN
    m = M'({1'b0, q[N-1:1]}) + M'(q[0]);
`else
    m = M'(q);
`endif
    s = m > MAXM ? MAXW : m[WIDTH_O-1:0];
    fin = neg ? -s : s;
  endfunction
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ready    <= 1'b1;
      ovalid   <= 1'b0;
      div0     <= 1'b0;
      result_r <= '0;
      result_i <= '0;
    end else begin
      ovalid <= 1'b0;
      case (state_q)
        IDLE: if (ivalid) begin
          ar_q    <= dataa_r;
          ai_q    <= dataa_i;
          br_q    <= datab_r;
          bi_q    <= datab_i;
          ready   <= 1'b0;
          state_q <= MULT;
        end
        MULT: begin
          zero_q  <= den == '0;
          neg_r_q <= num_r[P-1];
          neg_i_q <= num_i[P-1];
          den_q   <= den;
          rem_r_q <= '0;
          rem_i_q <= '0;
          quo_r_q <= {mag_r, (N - P)'(0)};
          quo_i_q <= {mag_i, (N - P)'(0)};
          cnt_q   <= CW'(N - 1);
          state_q <= den == '0 ? DONE : DIV;
        end
        DIV: begin
          {rem_r_q, quo_r_q} <= step(rem_r_q, quo_r_q, den_q);
          {rem_i_q, quo_i_q} <= step(rem_i_q, quo_i_q, den_q);
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == '0) state_q <= DONE;
        end
        default: begin
          result_r <= zero_q ? '0 : fin(quo_r_q, neg_r_q);
          result_i <= zero_q ? '0 : fin(quo_i_q, neg_i_q);
          div0     <= zero_q;
          ovalid   <= 1'b1;
          ready    <= 1'b1;
          state_q  <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cmpl_div.sv
// tb_cmpl_div: table-driven check of cmpl_div plus handshake and reset corner sequences
module tb_cmpl_div;
`ifdef CMPL_DIV_ROUND_EN
  localparam int LAT = 44;
  localparam bit RND = 1'b1;
`else
  localparam int LAT = 43;
  localparam bit RND = 1'b0;
`endif
  logic clock = 1'b0, reset = 1'b1, ivalid = 1'b0;
  logic [15:0] dataa_r = '0, dataa_i = '0, datab_r = '0, datab_i = '0;
  logic ready, ovalid, div0;
  logic [31:0] result_r, result_i;
  int total = 0, bad = 0;
  typedef struct {
    int ar, ai, br, bi;
    longint er, ei;
    bit ez;
    int lat;
  } vec_t;
  vec_t v[11];
  cmpl_div dut (
    .clock(clock), .reset(reset), .ivalid(ivalid), .ready(ready),
    .dataa_r(dataa_r), .dataa_i(dataa_i), .datab_r(datab_r), .datab_i(datab_i),
    .ovalid(ovalid), .result_r(result_r), .result_i(result_i), .div0(div0)
  );
  always #5 clock = ~clock;
  task automatic chk(input string nm, input logic signed [63:0] got, input logic signed [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask
  task automatic do_op(input vec_t x, input string nm);
    int w, lat;
    @(negedge clock);
    w = 0;
    while (!ready && w < 100) begin
      @(negedge clock);
      w++;
    end
    chk({nm, "_ready"}, ready, 1);
    dataa_r = 16'(x.ar);
    dataa_i = 16'(x.ai);
    datab_r = 16'(x.br);
    datab_i = 16'(x.bi);
    ivalid = 1'b1;
    @(posedge clock);
    #1 ivalid = 1'b0;
    lat = 0;
    while (!ovalid && lat < 100) begin
      @(posedge clock);
      #1 lat++;
    end
    chk({nm, "_lat"}, lat, x.lat);
    chk({nm, "_re"}, $signed(result_r), x.er);
    chk({nm, "_im"}, $signed(result_i), x.ei);
    chk({nm, "_div0"}, div0, x.ez);
  endtask
  initial begin
    int m, nov;
    v[0]  = '{-5, 10, 1, 2, 768, 1024, 1'b0, LAT};
    v[1]  = '{1, 0, 0, 2, 0, -128, 1'b0, LAT};
    v[2]  = '{-32768, 0, 1, 0, -8388608, 0, 1'b0, LAT};
    v[3]  = '{2, 0, 3, 0, RND ? 171 : 170, 0, 1'b0, LAT};
    v[4]  = '{1, 0, 3, 0, 85, 0, 1'b0, LAT};
    v[5]  = '{-2, 0, 3, 0, RND ? -171 : -170, 0, 1'b0, LAT};
    v[6]  = '{0, 2, 3, 0, 0, RND ? 171 : 170, 1'b0, LAT};
    v[7]  = '{5, 5, 0, 0, 0, 0, 1'b1, 2};
    v[8]  = '{3, 4, 3, 4, 256, 0, 1'b0, LAT};
    v[9]  = '{1, 1, 1, -1, 0, 256, 1'b0, LAT};
    v[10] = '{32767, -32768, -32768, -32768, 0, RND ? 256 : 255, 1'b0, LAT};
    repeat (3) @(posedge clock);
    #1;
    chk("rst_ready", ready, 1);
    chk("rst_ovalid", ovalid, 0);
    chk("rst_div0", div0, 0);
    chk("rst_re", $signed(result_r), 0);
    chk("rst_im", $signed(result_i), 0);
    @(negedge clock) reset = 1'b0;
    for (int i = 0; i < 11; i++) do_op(v[i], $sformatf("vec%0d", i));
    repeat (5) @(posedge clock);
    #1;
    chk("hold_re", $signed(result_r), v[10].er);
    chk("hold_im", $signed(result_i), v[10].ei);
    for (int c = 0; c < 3 * (LAT + 1); c++) begin
      @(negedge clock);
      dataa_r = 16'(c + 1);
      dataa_i = '0;
      datab_r = 16'(1);
      datab_i = '0;
      ivalid = 1'b1;
      @(posedge clock);
      #1;
      m = c % (LAT + 1);
      chk("stream_ready", ready, m == LAT);
      chk("stream_ovalid", ovalid, m == LAT);
      if (m == LAT) chk("stream_re", $signed(result_r), (c - LAT + 1) * 256);
    end
    @(negedge clock) ivalid = 1'b0;
    @(negedge clock);
    dataa_r = 16'(-5);
    dataa_i = 16'(10);
    datab_r = 16'(1);
    datab_i = 16'(2);
    ivalid = 1'b1;
    @(posedge clock);
    #1 ivalid = 1'b0;
    repeat (21) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    ivalid = 1'b1;
    @(posedge clock);
    #1;
    chk("mrst_ready", ready, 1);
    chk("mrst_ovalid", ovalid, 0);
    chk("mrst_re", $signed(result_r), 0);
    chk("mrst_im", $signed(result_i), 0);
    chk("mrst_div0", div0, 0);
    @(negedge clock);
    reset = 1'b0;
    ivalid = 1'b0;
    nov = 0;
    repeat (60) begin
      @(posedge clock);
      #1 if (ovalid) nov++;
    end
    chk("mrst_no_ovalid", nov, 0);
    do_op(v[0], "fresh");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
